// File: rtl/smiley_collision_pkg.sv
// Shared types for the smiley collision detector: channel indices and per-channel FSM states.
package smiley_collision_pkg;

  typedef enum logic [1:0] {CH_TOP, CH_LEFT, CH_RIGHT, CH_FLIPPER} coll_ch_e;
  localparam int NUM_COLL_CH = 4;

  typedef enum logic [1:0] {ST_ARMED, ST_REPORTED, ST_HOLDOFF} coll_state_e;

  // Hold-off counter width; a zero hold-off still gets a 1-bit counter.
  function automatic int holdoff_cnt_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/smiley_collision_channel.sv
// One collision channel: arm/report/hold-off FSM with a frame hold-off counter and a registered pulse.
module smiley_collision_channel
  import smiley_collision_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start_of_frame,
  input  logic pause,
  input  logic ovl,
  output logic pulse
);

  localparam int CW = holdoff_cnt_width(HOLDOFF_FRAMES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLDOFF_FRAMES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  coll_state_e    state;
  logic [CW-1:0]  cnt;
  logic           armed_now;
  logic           fire;

  // A REPORTED channel re-arms on the frame's first pixel and may fire on that same pixel.
  assign armed_now = (state == ST_ARMED) || ((state == ST_REPORTED) && start_of_frame);
  assign fire      = armed_now && ovl && !pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ARMED;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= fire;
      if (fire) begin
        if (HOLDOFF_FRAMES == 0) begin
          state <= ST_REPORTED;
        end else begin
          state <= ST_HOLDOFF;
          cnt   <= CNT_LOAD;
        end
      end else begin
        case (state)
          ST_REPORTED: if (start_of_frame) state <= ST_ARMED;
          ST_HOLDOFF: begin
            if (start_of_frame && !pause) begin
              if (cnt == CNT_ONE) state <= ST_REPORTED;
              cnt <= cnt - CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/smiley_collision_detector.sv
// Pixel-level smiley/scene collision detector with per-channel frame hold-off.
// Define SMILEY_COLLISION_COUNT_EN to add the saturating hitCount output.
module smiley_collision_detector
  import smiley_collision_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic        draw_smiley,
  input  logic        draw_border_top,
  input  logic        draw_border_left,
  input  logic        draw_border_right,
  input  logic        draw_flipper,
  output logic        collisionSmileyBorderTop,
  output logic        collisionSmileyBorderLeft,
  output logic        collisionSmileyBorderRight,
  output logic        collisionSmileyFlipper
`ifdef SMILEY_COLLISION_COUNT_EN
  ,
  output logic [15:0] hitCount
`endif
);

  logic [NUM_COLL_CH-1:0] draw_obj;
  logic [NUM_COLL_CH-1:0] ovl;
  logic [NUM_COLL_CH-1:0] pulse;

  assign draw_obj[CH_TOP]     = draw_border_top;
  assign draw_obj[CH_LEFT]    = draw_border_left;
  assign draw_obj[CH_RIGHT]   = draw_border_right;
  assign draw_obj[CH_FLIPPER] = draw_flipper;

  assign ovl = draw_obj & {NUM_COLL_CH{draw_smiley}};

  for (genvar g = 0; g < NUM_COLL_CH; g++) begin : g_ch
    smiley_collision_channel #(
      .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .start_of_frame(startOfFrame),
      .pause         (pause),
      .ovl           (ovl[g]),
      .pulse         (pulse[g])
    );
  end

  assign collisionSmileyBorderTop   = pulse[CH_TOP];
  assign collisionSmileyBorderLeft  = pulse[CH_LEFT];
  assign collisionSmileyBorderRight = pulse[CH_RIGHT];
  assign collisionSmileyFlipper     = pulse[CH_FLIPPER];

`ifdef SMILEY_COLLISION_COUNT_EN
  logic [2:0]  pulse_sum;
  logic [16:0] hit_sum;

  always_comb begin
    pulse_sum = '0;
    for (int i = 0; i < NUM_COLL_CH; i++) pulse_sum = pulse_sum + 3'(pulse[i]);
  end

  // Counts the registered pulses, so the count trails the pulses by one cycle.
  assign hit_sum = {1'b0, hitCount} + 17'(pulse_sum);

  always_ff @(posedge clk) begin
    if (reset) hitCount <= '0;
    else       hitCount <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_smiley_collision_detector.sv
// Bench for smiley_collision_detector: two instances (HOLDOFF_FRAMES=2 and 0) on shared stimulus.
module tb_smiley_collision_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, sof = 1'b0, pause = 1'b0, sm = 1'b0;
  logic dt = 1'b0, dl = 1'b0, dr = 1'b0, df = 1'b0;
  logic p0t, p0l, p0r, p0f, p1t, p1l, p1r, p1f;
  logic [3:0] got0, got1;
  assign got0 = {p0f, p0r, p0l, p0t};
  assign got1 = {p1f, p1r, p1l, p1t};
`ifdef SMILEY_COLLISION_COUNT_EN
  logic [15:0] h0, h1;
`endif

  smiley_collision_detector #(.HOLDOFF_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pause(pause), .draw_smiley(sm),
    .draw_border_top(dt), .draw_border_left(dl), .draw_border_right(dr), .draw_flipper(df),
    .collisionSmileyBorderTop(p0t), .collisionSmileyBorderLeft(p0l),
    .collisionSmileyBorderRight(p0r), .collisionSmileyFlipper(p0f)
`ifdef SMILEY_COLLISION_COUNT_EN
    , .hitCount(h0)
`endif
  );

  smiley_collision_detector #(.HOLDOFF_FRAMES(0)) dut0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pause(pause), .draw_smiley(sm),
    .draw_border_top(dt), .draw_border_left(dl), .draw_border_right(dr), .draw_flipper(df),
    .collisionSmileyBorderTop(p1t), .collisionSmileyBorderLeft(p1l),
    .collisionSmileyBorderRight(p1r), .collisionSmileyFlipper(p1f)
`ifdef SMILEY_COLLISION_COUNT_EN
    , .hitCount(h1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a channel that pulsed must see hold[i] unpaused frame starts,
  // then one more frame start, before it is eligible again.
  int         hold[2] = '{2, 0};
  bit         disarmed[2][4];
  int         frames_left[2][4];
  logic [3:0] exp_p[2];
  int         exp_hit[2];

  task automatic tick();
    logic [3:0] ov;
    @(posedge clk);
    ov = {df, dr, dl, dt} & {4{sm}};
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        exp_p[i] = '0;
        exp_hit[i] = 0;
        for (int c = 0; c < 4; c++) begin
          disarmed[i][c] = 1'b0;
          frames_left[i][c] = 0;
        end
      end else begin
        exp_hit[i] = exp_hit[i] + $countones(exp_p[i]);
        if (exp_hit[i] > 65535) exp_hit[i] = 65535;
        for (int c = 0; c < 4; c++) begin
          if (disarmed[i][c] && sof) begin
            if (frames_left[i][c] > 0) begin
              if (!pause) frames_left[i][c]--;
            end else begin
              disarmed[i][c] = 1'b0;
            end
          end
          exp_p[i][c] = !disarmed[i][c] && ov[c] && !pause;
          if (exp_p[i][c]) begin
            disarmed[i][c] = 1'b1;
            frames_left[i][c] = hold[i];
          end
        end
      end
    end
    #1;
  endtask

  task automatic set_in(input logic s, input logic p, input logic m, input logic [3:0] o);
    sof = s; pause = p; sm = m; {df, dr, dl, dt} = o;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 4'h0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One frame of len pixels; objects in mask overlap the smiley for width pixels from pos.
  task automatic run_frame(input int len, input int pos, input int width, input logic [3:0] mask,
                           input logic p, output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int k = 0; k < len; k++) begin
      if (k >= pos && k < pos + width) set_in(k == 0, p, 1'b1, mask);
      else set_in(k == 0, p, 1'b0, 4'h0);
      tick();
      c0 += $countones(got0 & mask);
      c1 += $countones(got1 & mask);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 4'hF);
    tick();
    tick();
    n_vec++;
    if (got0 !== 4'h0 || got1 !== 4'h0) begin
      n_err++; $display("FAIL reset_outputs got h2=%b h0=%b required 0000", got0, got1);
    end
    reset = 1'b0;
    tick();
    n_vec++;
    if (got0 !== 4'hF || got1 !== 4'hF) begin
      n_err++; $display("FAIL first_cycle_after_reset got h2=%b h0=%b required 1111", got0, got1);
    end
    set_in(1'b0, 1'b0, 1'b1, 4'hF);
    tick();
    n_vec++;
    if (got0 !== 4'h0 || got1 !== 4'h0) begin
      n_err++; $display("FAIL no_retrigger got h2=%b h0=%b required 0000", got0, got1);
    end
  endtask

  task automatic test_single_top();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 4'h0); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'h0); tick();
    n_vec++;
    if (got0 !== 4'h0 || got1 !== 4'h0) begin
      n_err++; $display("FAIL top_idle got h2=%b h0=%b required 0000", got0, got1);
    end
    set_in(1'b0, 1'b0, 1'b1, 4'b0001); tick();
    n_vec++;
    if (got0 !== 4'b0001 || got1 !== 4'b0001) begin
      n_err++; $display("FAIL top_pulse got h2=%b h0=%b required 0001", got0, got1);
    end
    set_in(1'b0, 1'b0, 1'b0, 4'h0); tick();
    n_vec++;
    if (got0 !== 4'h0 || got1 !== 4'h0) begin
      n_err++; $display("FAIL top_pulse_width got h2=%b h0=%b required 0000", got0, got1);
    end
  endtask

  task automatic test_left_holdoff();
    logic [5:0] fr0, fr1;
    int c0, c1, tot0;
    fr0 = '0; fr1 = '0; tot0 = 0;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      run_frame(8, 3, 1, 4'b0010, 1'b0, c0, c1);
      fr0[f] = (c0 != 0);
      fr1[f] = (c1 != 0);
      tot0 += c0;
    end
    n_vec++;
    if (fr0 !== 6'b001001) begin
      n_err++; $display("FAIL left_holdoff_frames got %b required 001001", fr0);
    end
    n_vec++;
    if (fr1 !== 6'b111111) begin
      n_err++; $display("FAIL left_noholdoff_frames got %b required 111111", fr1);
    end
    n_vec++;
    if (tot0 !== 2) begin
      n_err++; $display("FAIL left_holdoff_total got %0d required 2", tot0);
    end
  endtask

  task automatic test_flipper_run();
    int c0, c1, tot0, tot1;
    tot0 = 0; tot1 = 0;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(30, 1, 20, 4'b1000, 1'b0, c0, c1);
      tot0 += c0;
      tot1 += c1;
    end
    n_vec++;
    if (tot1 !== 3) begin
      n_err++; $display("FAIL flipper_run_h0 got %0d pulses required 3", tot1);
    end
    n_vec++;
    if (tot0 !== 1) begin
      n_err++; $display("FAIL flipper_run_h2 got %0d pulses required 1", tot0);
    end
  endtask

  task automatic test_pause();
    int c0, c1;
    do_reset();
    run_frame(6, 0, 0, 4'b0100, 1'b0, c0, c1);
    run_frame(6, 2, 1, 4'b0100, 1'b1, c0, c1);
    n_vec++;
    if (c0 !== 0 || c1 !== 0) begin
      n_err++; $display("FAIL pause_frame got h2=%0d h0=%0d required 0", c0, c1);
    end
    run_frame(6, 2, 1, 4'b0100, 1'b0, c0, c1);
    n_vec++;
    if (c0 !== 1 || c1 !== 1) begin
      n_err++; $display("FAIL after_pause_frame got h2=%0d h0=%0d required 1", c0, c1);
    end
  endtask

  task automatic test_sof_coincident();
    int c0, c1;
    do_reset();
    run_frame(6, 2, 1, 4'b0001, 1'b0, c0, c1);
    set_in(1'b1, 1'b0, 1'b1, 4'b0001); tick();
    n_vec++;
    if (got1[0] !== 1'b1 || got0[0] !== 1'b0) begin
      n_err++; $display("FAIL sof_coincident got h2=%b h0=%b required h2=0 h0=1", got0[0], got1[0]);
    end
    set_in(1'b0, 1'b0, 1'b1, 4'b0001); tick();
    n_vec++;
    if (got1[0] !== 1'b0) begin
      n_err++; $display("FAIL sof_coincident_disarm got %b required 0", got1[0]);
    end
  endtask

  task automatic test_reset_mid_holdoff();
    int c0, c1;
    do_reset();
    run_frame(6, 2, 1, 4'b0001, 1'b0, c0, c1);
    set_in(1'b1, 1'b0, 1'b0, 4'h0); tick();
    set_in(1'b0, 1'b0, 1'b1, 4'b0001); tick();
    n_vec++;
    if (got0[0] !== 1'b0) begin
      n_err++; $display("FAIL holdoff_blocks got %b required 0", got0[0]);
    end
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 4'h0); tick();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b1, 4'b0001); tick();
    n_vec++;
    if (got0[0] !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_holdoff got %b required 1", got0[0]);
    end
  endtask

  task automatic test_random();
    int k, flen;
    logic p;
    do_reset();
    k = 0; flen = 8; p = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (k == 0) begin
        flen = $urandom_range(6, 20);
        p = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 49) == 0) p = ~p;
      set_in(k == 0, p, $urandom_range(0, 1) == 1,
             {$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3});
      reset = ($urandom_range(0, 599) == 0);
      k = (k + 1 == flen) ? 0 : k + 1;
      tick();
      n_vec++;
      if (got0 !== exp_p[0] || got1 !== exp_p[1]) begin
        n_err++;
        $display("FAIL random_pulses t=%0t got h2=%b h0=%b required h2=%b h0=%b",
                 $time, got0, got1, exp_p[0], exp_p[1]);
      end
`ifdef SMILEY_COLLISION_COUNT_EN
      n_vec++;
      if (h0 !== 16'(exp_hit[0]) || h1 !== 16'(exp_hit[1])) begin
        n_err++;
        $display("FAIL random_hitcount got h2=%0d h0=%0d required h2=%0d h0=%0d",
                 h0, h1, exp_hit[0], exp_hit[1]);
      end
`endif
    end
    reset = 1'b0;
  endtask

`ifdef SMILEY_COLLISION_COUNT_EN
  task automatic test_hit_count();
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 4'b0011); tick();
    n_vec++;
    if (got0 !== 4'b0011 || got1 !== 4'b0011) begin
      n_err++; $display("FAIL dual_pulse got h2=%b h0=%b required 0011", got0, got1);
    end
    set_in(1'b0, 1'b0, 1'b0, 4'h0); tick();
    n_vec++;
    if (h0 !== 16'd2 || h1 !== 16'd2) begin
      n_err++; $display("FAIL hitcount_plus2 got h2=%0d h0=%0d required 2", h0, h1);
    end
    // Zero hold-off with a frame start every pixel: four pulses per cycle.
    for (int n = 0; n < 16383; n++) begin
      set_in(1'b1, 1'b0, 1'b1, 4'hF); tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 4'h0); tick();
    n_vec++;
    if (h1 !== 16'hFFFE) begin
      n_err++; $display("FAIL hitcount_preload got %h required fffe", h1);
    end
    set_in(1'b1, 1'b0, 1'b1, 4'b0011); tick();
    set_in(1'b0, 1'b0, 1'b0, 4'h0); tick();
    n_vec++;
    if (h1 !== 16'hFFFF) begin
      n_err++; $display("FAIL hitcount_saturate got %h required ffff", h1);
    end
    n_vec++;
    if (h0 !== 16'(exp_hit[0])) begin
      n_err++; $display("FAIL hitcount_h2 got %0d required %0d", h0, exp_hit[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_top();
    test_left_holdoff();
    test_flipper_run();
    test_pause();
    test_sof_coincident();
    test_reset_mid_holdoff();
    test_random();
`ifdef SMILEY_COLLISION_COUNT_EN
    test_hit_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
